monotonize_stream_pipe: RTL and testbench
=========================================

// Module: monotonize_stream_pipe
// PURPOSE
//  Streaming monotone-closure unit for Boolean functions on VAR_COUNT variables (2**VAR_COUNT-bit truth tables).
//  Per transaction, selects upward closure (set bit i if any subset j of i is set) or downward closure (set bit i if any superset is set).
//  Stage registers are selected at elaboration time. Flow control is valid/ready with bubble collapsing.
//  A sideband tag travels with each item. Sits between the function-source FIFOs and the permutation/count stages.
// PARAMETERS
//  VAR_COUNT  7         number of variables; W = 2**VAR_COUNT data bits (legal range 1..10)
//  REG_MASK   7'h55     VAR_COUNT bits; bit k=1 places a register after OR-stage k; L = popcount(REG_MASK)
//  TAG_W      8         sideband tag width (>=1)
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      input item valid
//  in_ready   out  1      block can accept an input item this cycle
//  in_down    in   1      0 = upward closure, 1 = downward closure
//  in_data    in   W      input truth table; bit i = f(i)
//  in_tag     in   TAG_W  opaque sideband, returned unchanged
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts the result
//  out_data   out  W      monotone closure of in_data
//  out_tag    out  TAG_W  tag of the item on out_data
//  out_down   out  1      mode bit of the item on out_data
//  busy       out  1      1 if any pipeline stage holds a valid item
// BEHAVIOUR
//  - OR-stage k, for k = 0..VAR_COUNT-1 in ascending order, on every bit i:
//    - Up mode: if bit k of i is 1, d'[i] = d[i] | d[i - 2**k]; otherwise d'[i] = d[i].
//    - Down mode: if bit k of i is 0, d'[i] = d[i] | d[i + 2**k]; otherwise d'[i] = d[i].
//    - The mode bit travels with the item, so stages are selected per item. Up and down items may be interleaved back-to-back.
//  - Each register slot s holds {valid, down, tag, data}.
//    - Slot s loads when (!v[s] || ready[s+1]). The last slot uses out_ready as ready[s+1]; in_ready = ready[0].
//    - The ready path is combinational through the slots. A bubble in any slot lets upstream items advance while the output is stalled.
//  - Latency is exactly L cycles from input handshake to out_valid when there is no backpressure. Throughput is 1 item per cycle.
//  - L = 0 (REG_MASK = 0): purely combinational path. in_ready = out_ready, out_valid = in_valid, and out_* is a function of in_*.
//  - Stall rule: a slot with v=1 whose downstream is not ready holds its data, tag and down bits stable.
//    out_data/out_tag/out_down must not change while out_valid && !out_ready.
//  - Capacity is L items; there is no loss and no duplication. Items are strictly in order.
//  - busy = OR of all slot valid bits. busy = 0 when L = 0.
//  - Reset (async assert, de-assert synchronous to clk):
//    - All valid bits 0; data, tag and down registers 0.
//    - out_valid = 0, busy = 0. When L > 0, in_ready = 1 after de-assert.
//    - Items in flight when rst asserts are discarded and never emitted.
//  - An input with in_valid && !in_ready must be held by the source. The block does not sample it.
//  - Idempotence: feeding out_data back in the same mode returns it unchanged.
// TESTING (VAR_COUNT=7, REG_MASK=7'h55, L=4, TAG_W=8 unless noted)
//  1. Up, in_data = bit 0 only, tag 8'hA5
//     -> after 4 cycles: out_data = all ones, out_tag = 8'hA5, out_down = 0.
//  2. Down, in_data = bit 64 only
//     -> out_data bits {0, 64} set, all other bits 0.
//     Up, in_data = bit 64 only -> out_data = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0}.
//  3. Back-to-back stream of 20 random items with alternating mode, out_ready held at 1
//     -> 20 outputs in order, one per cycle, matching a software model, and tags preserved.
//  4. Fill the pipeline, then hold out_ready = 0 for 10 cycles
//     -> in_ready falls after 4 accepts, out_* is stable, then all 4 items drain in order with no loss.
//     Also insert a single bubble and confirm it collapses.
//  5. Assert rst for 1 cycle with 3 items in flight, mid-stall
//     -> out_valid and busy drop immediately; none of the 3 items ever appears; the next item has latency 4.
//  6. Parameter sweep {VAR_COUNT=1, REG_MASK=0} and {VAR_COUNT=4, REG_MASK=4'hF}
//     -> combinational pass-through with latency 0, then latency 4.
//     In each case, input 4'h1 up -> 16'hFFFF when VAR_COUNT=4.

Source files
------------

// File: rtl/monotonize_stream_pipe.sv
// monotonize_stream_pipe
//   Streaming monotone-closure unit for Boolean functions of VAR_COUNT
//   variables (W = 2**VAR_COUNT truth-table bits). Each item selects upward
//   closure (bit i set if any subset of i is set) or downward closure (bit i
//   set if any superset of i is set). The closure is built from VAR_COUNT
//   OR-stages. REG_MASK picks at elaboration time which stages are followed
//   by a pipeline register slot. Slots use valid/ready handshaking with
//   bubble collapsing.
//
// Ports
//   clk, rst              clock (rising edge), async active-high reset
//   in_valid / in_ready   input handshake
//   in_down               0 = upward closure, 1 = downward closure
//   in_data               input truth table, bit i = f(i)
//   in_tag                opaque sideband, returned unchanged
//   out_valid / out_ready output handshake
//   out_data              monotone closure of the item's in_data
//   out_tag / out_down    tag and mode of the item on out_data
//   busy                  any register slot holds a valid item
module monotonize_stream_pipe #(
  parameter int unsigned          VAR_COUNT = 7,
  parameter logic [VAR_COUNT-1:0] REG_MASK  = 7'h55,
  parameter int unsigned          TAG_W     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_down,
  input  logic [(1<<VAR_COUNT)-1:0] in_data,
  input  logic [TAG_W-1:0]          in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [(1<<VAR_COUNT)-1:0] out_data,
  output logic [TAG_W-1:0]          out_tag,
  output logic                      out_down,
  output logic                      busy
);

  localparam int unsigned W  = 1 << VAR_COUNT;
  localparam int unsigned AW = VAR_COUNT;

  function automatic int unsigned count_regs(input logic [VAR_COUNT-1:0] m);
    int unsigned n;
    n = 0;
    for (int unsigned k = 0; k < VAR_COUNT; k++) begin
      if (m[k]) n++;
    end
    return n;
  endfunction

  localparam int unsigned L  = count_regs(REG_MASK);
  // Arrays keep at least one entry so the L = 0 build stays legal.
  localparam int unsigned LQ = (L == 0) ? 1 : L;
  localparam int unsigned SW = (LQ > 1) ? $clog2(LQ) : 1;

  typedef struct packed {
    logic             v;
    logic             dn;
    logic [TAG_W-1:0] tag;
    logic [W-1:0]     d;
  } item_t;

  // One OR-stage along variable k, direction chosen per item.
  function automatic logic [W-1:0] or_stage(input logic [W-1:0] d,
                                            input logic         dn,
                                            input int unsigned  k);
    logic [W-1:0] r;
    int unsigned  p;
    r = d;
    p = 32'd1 << k;
    for (int unsigned i = 0; i < W; i++) begin
      if (dn && ((i & p) == 0)) begin
        r[AW'(i)] = d[AW'(i)] | d[AW'(i + p)];
      end else if (!dn && ((i & p) != 0)) begin
        r[AW'(i)] = d[AW'(i)] | d[AW'(i - p)];
      end
    end
    return r;
  endfunction

  item_t          slot_q  [LQ];
  item_t          slot_d  [LQ];
  logic  [LQ-1:0] slot_ld;
  item_t          cur;

  // Datapath: walk the stages in order; wherever a register sits, the
  // combinational result feeds that slot and the slot's output continues.
  always_comb begin
    logic [VAR_COUNT-1:0] m;
    int unsigned          s;
    for (int unsigned j = 0; j < LQ; j++) begin
      slot_d[SW'(j)] = '0;
    end
    m       = REG_MASK;
    s       = 0;
    cur.v   = in_valid;
    cur.dn  = in_down;
    cur.tag = in_tag;
    cur.d   = in_data;
    for (int unsigned k = 0; k < VAR_COUNT; k++) begin
      cur.d = or_stage(cur.d, cur.dn, k);
      if (m[0]) begin
        slot_d[SW'(s)] = cur;
        cur            = slot_q[SW'(s)];
        s++;
      end
      m = m >> 1;
    end
    out_valid = cur.v;
    out_down  = cur.dn;
    out_tag   = cur.tag;
    out_data  = cur.d;
  end

  // Ready ripples backwards from out_ready; an empty slot always accepts,
  // which is what lets bubbles collapse during an output stall.
  always_comb begin
    logic        r;
    int unsigned s;
    slot_ld = '0;
    busy    = 1'b0;
    r       = out_ready;
    for (int unsigned j = 0; j < L; j++) begin
      s                 = L - 1 - j;
      slot_ld[SW'(s)]   = !slot_q[SW'(s)].v || r;
      r                 = slot_ld[SW'(s)];
      busy              = busy | slot_q[SW'(s)].v;
    end
    in_ready = r;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned j = 0; j < LQ; j++) begin
        slot_q[SW'(j)] <= '0;
      end
    end else begin
      for (int unsigned j = 0; j < L; j++) begin
        if (slot_ld[SW'(j)]) slot_q[SW'(j)] <= slot_d[SW'(j)];
      end
    end
  end

endmodule

// File: tb/tb_monotonize_stream_pipe.sv
module tb_monotonize_stream_pipe;

  localparam int unsigned LAT = 4;

  logic         clk = 1'b0;
  logic         rst;

  // Main instance: VAR_COUNT=7, REG_MASK=7'h55
  logic         in_valid, in_ready, in_down;
  logic [127:0] in_data;
  logic [7:0]   in_tag;
  logic         out_valid, out_ready, out_down, busy;
  logic [127:0] out_data;
  logic [7:0]   out_tag;

  // Combinational instance: VAR_COUNT=1, REG_MASK=0
  logic         a_in_valid, a_in_ready, a_in_down, a_out_valid, a_out_ready, a_out_down, a_busy;
  logic [1:0]   a_in_data, a_out_data;
  logic [7:0]   a_in_tag, a_out_tag;

  // Four-register instance: VAR_COUNT=4, REG_MASK=4'hF
  logic         b_in_valid, b_in_ready, b_in_down, b_out_valid, b_out_ready, b_out_down, b_busy;
  logic [15:0]  b_in_data, b_out_data;
  logic [7:0]   b_in_tag, b_out_tag;

  monotonize_stream_pipe #(.VAR_COUNT(7), .REG_MASK(7'h55), .TAG_W(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_down(in_down),
    .in_data(in_data), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .out_down(out_down), .busy(busy));

  monotonize_stream_pipe #(.VAR_COUNT(1), .REG_MASK(1'b0), .TAG_W(8)) u_dut_comb (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_down(a_in_down),
    .in_data(a_in_data), .in_tag(a_in_tag), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_tag(a_out_tag), .out_down(a_out_down), .busy(a_busy));

  monotonize_stream_pipe #(.VAR_COUNT(4), .REG_MASK(4'hF), .TAG_W(8)) u_dut_v4 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_down(b_in_down),
    .in_data(b_in_data), .in_tag(b_in_tag), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_tag(b_out_tag), .out_down(b_out_down), .busy(b_busy));

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] d;
    logic [7:0]   tag;
    logic         dn;
    int unsigned  cyc;
  } exp_t;

  exp_t         sb[$];
  int unsigned  checks   = 0;
  int unsigned  failures = 0;
  int unsigned  cyc      = 0;
  int unsigned  n_out    = 0;
  logic         lat_check = 1'b0;
  logic [127:0] last_d   = '0;

  // Reference closure straight from the definition: bit i is set if some set
  // bit j is a subset (up) or superset (down) of i.
  function automatic logic [127:0] clos(input logic [127:0] d, input logic dn, input int unsigned n);
    logic [127:0] r;
    r = '0;
    for (int unsigned i = 0; i < (32'd1 << n); i++) begin
      for (int unsigned j = 0; j < (32'd1 << n); j++) begin
        if (d[7'(j)] && (dn ? ((i & ~j) == 0) : ((j & ~i) == 0))) r[7'(i)] = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes at the falling edge, then advance.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (in_valid && in_ready) begin
      e.d = clos(in_data, in_down, 7); e.tag = in_tag; e.dn = in_down; e.cyc = cyc;
      sb.push_back(e);
    end
    if (out_valid && out_ready) begin
      chk("spurious_out", 128'(sb.size() > 0), 128'(1));
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_tag", 128'(out_tag), 128'(e.tag));
        chk("out_down", 128'(out_down), 128'(e.dn));
        if (lat_check) chk("latency", 128'(cyc - e.cyc), 128'(LAT));
        n_out++;
        last_d = out_data;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input int unsigned bound);
    for (int unsigned k = 0; k < bound && sb.size() > 0; k++) step();
    chk("drain_empty", 128'(sb.size()), 128'(0));
  endtask

  task automatic set_item(input logic [127:0] d, input logic dn, input logic [7:0] tag);
    in_data = d; in_down = dn; in_tag = tag; in_valid = 1'b1;
  endtask

  task automatic set_rand(input logic dn);
    logic [127:0] d;
    if ($urandom_range(1) == 1) d = {$urandom, $urandom, $urandom, $urandom};
    else begin
      d = '0;
      for (int k = 0; k < 3; k++) d[7'($urandom_range(127))] = 1'b1;
    end
    set_item(d, dn, 8'($urandom));
  endtask

  task automatic fill_until_full(input int unsigned start_acc);
    int unsigned acc;
    logic hs;
    acc = start_acc;
    set_rand(1'($urandom_range(1)));
    for (int unsigned t = 0; t < 8; t++) begin
      chk("fill_in_ready", 128'(in_ready), 128'(acc < LAT));
      hs = in_ready;
      step();
      if (hs) begin
        acc++;
        set_rand(1'($urandom_range(1)));
      end
    end
    in_valid = 1'b0;
    chk("fill_count", 128'(acc), 128'(LAT));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] c, x;
    int unsigned  n0, lat;
    logic [1:0]   a_d;
    rst = 1'b1;
    in_valid = 1'b0; in_down = 1'b0; in_data = '0; in_tag = '0; out_ready = 1'b1;
    a_in_valid = 1'b0; a_in_down = 1'b0; a_in_data = '0; a_in_tag = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_down = 1'b0; b_in_data = '0; b_in_tag = '0; b_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_data", out_data, 128'(0));
    chk("rst_out_tag", 128'(out_tag), 128'(0));

    // 1: up, single bit 0
    lat_check = 1'b1;
    c = '0; c[0] = 1'b1;
    set_item(c, 1'b0, 8'hA5);
    step();
    in_valid = 1'b0;
    drain(10);
    c = '1;
    chk("t1_all_ones", last_d, c);

    // 2: down and up on bit 64
    c = '0; c[64] = 1'b1;
    set_item(c, 1'b1, 8'h11);
    step();
    in_valid = 1'b0;
    drain(10);
    c = '0; c[0] = 1'b1; c[64] = 1'b1;
    chk("t2_down_bit64", last_d, c);
    c = '0; c[64] = 1'b1;
    set_item(c, 1'b0, 8'h22);
    step();
    in_valid = 1'b0;
    drain(10);
    chk("t2_up_bit64", last_d, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0});

    // Idempotence: an already-closed function passes unchanged
    c = '0; c[7'($urandom_range(127))] = 1'b1; c[7'($urandom_range(127))] = 1'b1;
    x = clos(c, 1'b0, 7);
    set_item(x, 1'b0, 8'h33);
    step();
    in_valid = 1'b0;
    drain(10);
    chk("idempotent", last_d, x);

    // 3: 20 back-to-back items, alternating mode
    n0 = n_out;
    for (int unsigned i = 0; i < 20; i++) begin
      set_rand(1'(i & 1));
      chk("stream_in_ready", 128'(in_ready), 128'(1));
      step();
    end
    in_valid = 1'b0;
    drain(20);
    chk("stream_count", 128'(n_out - n0), 128'(20));

    // 4: fill under stall, hold 10 cycles, drain
    lat_check = 1'b0;
    out_ready = 1'b0;
    fill_until_full(0);
    for (int unsigned i = 0; i < 10; i++) begin
      chk("stall_valid", 128'(out_valid), 128'(1));
      chk("stall_data", out_data, sb[0].d);
      chk("stall_tag", 128'(out_tag), 128'(sb[0].tag));
      step();
    end
    out_ready = 1'b1;
    n0 = n_out;
    drain(20);
    chk("stall_drain_count", 128'(n_out - n0), 128'(LAT));

    // 4b: a bubble between items collapses during the stall
    out_ready = 1'b0;
    set_rand(1'b0);
    step();
    in_valid = 1'b0;
    step();
    set_rand(1'b1);
    step();
    in_valid = 1'b0;
    step();
    step();
    fill_until_full(2);
    out_ready = 1'b1;
    n0 = n_out;
    drain(20);
    chk("bubble_drain_count", 128'(n_out - n0), 128'(LAT));

    // 5: reset with 3 items in flight mid-stall
    out_ready = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      set_rand(1'(i & 1));
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    chk("pre_rst_busy", 128'(busy), 128'(1));
    rst = 1'b1;
    #1;
    chk("rst_async_out_valid", 128'(out_valid), 128'(0));
    chk("rst_async_busy", 128'(busy), 128'(0));
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("post_rst_in_ready", 128'(in_ready), 128'(1));
    out_ready = 1'b1;
    n0 = n_out;
    for (int unsigned i = 0; i < 8; i++) step();
    chk("rst_no_ghosts", 128'(n_out - n0), 128'(0));
    lat_check = 1'b1;
    set_rand(1'b0);
    step();
    in_valid = 1'b0;
    drain(10);
    chk("post_rst_count", 128'(n_out - n0), 128'(1));

    // 6a: VAR_COUNT=1, REG_MASK=0 is purely combinational
    for (int unsigned i = 0; i < 4; i++) begin
      a_d = 2'(i);
      a_in_data = a_d;
      a_in_down = 1'(i >> 1);
      a_in_tag = 8'($urandom);
      a_in_valid = 1'(i & 1);
      a_out_ready = ~1'(i & 1);
      #1;
      x = clos(128'(a_d), a_in_down, 1);
      chk("comb_data", 128'(a_out_data), 128'(x[1:0]));
      chk("comb_valid", 128'(a_out_valid), 128'(a_in_valid));
      chk("comb_ready", 128'(a_in_ready), 128'(a_out_ready));
      chk("comb_tag", 128'(a_out_tag), 128'(a_in_tag));
      chk("comb_busy", 128'(a_busy), 128'(0));
    end
    a_in_data = 2'b01; a_in_down = 1'b0; #1;
    chk("comb_up_01", 128'(a_out_data), 128'(2'b11));

    // 6b: VAR_COUNT=4, REG_MASK=4'hF has latency 4
    chk("v4_in_ready", 128'(b_in_ready), 128'(1));
    b_in_data = 16'h0001; b_in_down = 1'b0; b_in_tag = 8'h5A; b_in_valid = 1'b1;
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    lat = 1;
    while (!b_out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("v4_latency", 128'(lat), 128'(LAT));
    chk("v4_data", 128'(b_out_data), 128'(16'hFFFF));
    chk("v4_tag", 128'(b_out_tag), 128'(8'h5A));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
